// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared types, constants and helpers for the button event controller
package btn_evt_pkg;

  localparam int TS_W       = 16;
  localparam int CHAN_MAX_W = 4;

  typedef struct packed {
    logic [CHAN_MAX_W-1:0] chan;
    logic                  fall;
`ifdef BUTTON_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]       ts;
`endif
  } evt_entry_t;

  function automatic int chan_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// rtl/btn_evt_fifo.sv - synchronous FIFO with registered full/empty and zeroed head while empty
module btn_evt_fifo #(
  parameter int DW       = 3,
  parameter int DEPTH_LG = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << DEPTH_LG;

  logic [DW-1:0]       mem_q [DEPTH];
  logic [DEPTH_LG-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LG:0]   count_q, count_d;
  logic                full_q, empty_q;
  logic                do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + 1'b1;
    else if (do_pop && !do_push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      // Count never exceeds DEPTH, so its MSB alone marks full
      full_q  <= count_d[DEPTH_LG];
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/debouncer.sv
// rtl/debouncer.sv - multi-channel debouncer; one shared timer samples all channels every 2^LGWAIT cycles
module debouncer #(
  parameter int NIN    = 4,
  parameter int LGWAIT = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NIN-1:0] raw_i,
  output logic [NIN-1:0] deb_o
);

  logic [LGWAIT-1:0] timer_q;
  logic [NIN-1:0]    sync1_q;
  logic [NIN-1:0]    sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      deb_o   <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      // All channels update together on the tick, so simultaneous presses land in one cycle
      if (timer_q == '0)
        deb_o <= sync2_q;
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounced button edges queued as events with valid/ready pop and level irq
// Define BUTTON_EVT_TIMESTAMP_EN to add a tick-based timestamp (evt_time) to each event.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LGWAIT   = 20,
  parameter int DEPTH_LG = 2,
  parameter int CHW      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] level_out,
`ifdef BUTTON_EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]  evt_time,
`endif
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CHW-1:0]   evt_chan,
  output logic             evt_fall,
  output logic             irq,
  output logic             overflow,
  input  logic             ovf_clr
);

`ifdef BUTTON_EVT_TIMESTAMP_EN
  localparam int EW = CHW + 1 + TS_W;
`else
  localparam int EW = CHW + 1;
`endif

  logic [WIDTH-1:0] deb, prev_q;
  logic [WIDTH-1:0] new_r, new_f;
  logic [WIDTH-1:0] pend_r_q, pend_r_d, pend_f_q, pend_f_d;
  logic [WIDTH-1:0] sel_mask, clr_r, clr_f;
  logic             ovf_q, ovf_d, ovf_set;
  logic             sel_found, sel_fall, push;
  logic [CHW-1:0]   sel_chan;
  evt_entry_t       sel_evt;
  logic [EW-1:0]    push_data, head_data;
  logic             fifo_full, fifo_empty;

  debouncer #(.NIN(WIDTH), .LGWAIT(LGWAIT)) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw_i (raw_in),
    .deb_o (deb)
  );

  assign new_r = deb & ~prev_q & rise_en;
  assign new_f = ~deb & prev_q & fall_en;

  // Lowest pending channel wins; on that channel rise goes before fall
  always_comb begin
    sel_found = 1'b0;
    sel_chan  = '0;
    sel_fall  = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_r_q[i] || pend_f_q[i]) begin
        sel_found = 1'b1;
        sel_chan  = CHW'(i);
        sel_fall  = ~pend_r_q[i];
      end
    end
  end

  assign push     = sel_found & ~fifo_full;
  assign sel_mask = push ? (WIDTH'(1) << sel_chan) : '0;
  assign clr_r    = sel_fall ? '0 : sel_mask;
  assign clr_f    = sel_fall ? sel_mask : '0;

  // A fresh edge on a flag that stays set this cycle is merged into the waiting event
  always_comb begin
    pend_r_d = (pend_r_q & ~clr_r) | new_r;
    pend_f_d = (pend_f_q & ~clr_f) | new_f;
    ovf_set  = (|(new_r & pend_r_q & ~clr_r)) | (|(new_f & pend_f_q & ~clr_f));
    ovf_d    = ovf_q;
    if (ovf_set)
      ovf_d = 1'b1;
    else if (ovf_clr)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= '0;
      pend_r_q <= '0;
      pend_f_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= deb;
      pend_r_q <= pend_r_d;
      pend_f_q <= pend_f_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef BUTTON_EVT_TIMESTAMP_EN
  // Mirrors the debouncer timer: both reset to zero and count every cycle, so ticks coincide
  logic [LGWAIT-1:0] ts_tmr_q;
  logic [TS_W-1:0]   ts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_tmr_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_tmr_q <= ts_tmr_q + 1'b1;
      if (ts_tmr_q == '0)
        ts_q <= ts_q + 1'b1;
    end
  end
`endif

  always_comb begin
    sel_evt      = '0;
    sel_evt.chan = CHAN_MAX_W'(sel_chan);
    sel_evt.fall = sel_fall;
`ifdef BUTTON_EVT_TIMESTAMP_EN
    sel_evt.ts   = ts_q;
    push_data    = {CHW'(sel_evt.chan), sel_evt.fall, sel_evt.ts};
`else
    push_data    = {CHW'(sel_evt.chan), sel_evt.fall};
`endif
  end

  btn_evt_fifo #(.DW(EW), .DEPTH_LG(DEPTH_LG)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (evt_ready),
    .head_o      (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign level_out = deb;
  assign evt_valid = ~fifo_empty;
  assign irq       = ~fifo_empty;
  assign evt_chan  = head_data[EW-1 -: CHW];
  assign evt_fall  = head_data[EW-1-CHW];
  assign overflow  = ovf_q;
`ifdef BUTTON_EVT_TIMESTAMP_EN
  assign evt_time  = head_data[TS_W-1:0];
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - directed scoreboard bench for button_event_ctrl
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] raw_in = 4'h0;
  logic [3:0] rise_en = 4'hF;
  logic [3:0] fall_en = 4'hF;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  wire  [3:0] level_out;
  wire        evt_valid, irq, overflow, evt_fall;
  wire  [1:0] evt_chan;
`ifdef BUTTON_EVT_TIMESTAMP_EN
  wire [15:0] evt_time;
`endif

  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] exp_q[$];

  button_event_ctrl #(.WIDTH(4), .LGWAIT(3), .DEPTH_LG(2), .CHW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .level_out (level_out),
`ifdef BUTTON_EVT_TIMESTAMP_EN
    .evt_time  (evt_time),
`endif
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_fall  (evt_fall),
    .irq       (irq),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input logic [3:0] exp, input string tag);
    int k = 0;
    while (level_out !== exp && k < 64) begin
      @(negedge clk);
      k++;
    end
    check(tag, level_out, exp);
  endtask

  task automatic pop_check(input string tag);
    int k = 0;
    logic [2:0] e;
    while (evt_valid !== 1'b1 && k < 32) begin
      @(negedge clk);
      k++;
    end
    check({tag, " valid"}, evt_valid, 1);
    check({tag, " irq"}, irq, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
    check({tag, " entry"}, {evt_chan, evt_fall}, e);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    logic [2:0] head_exp;

    // Reset state
    step(3);
    check("rst level", level_out, 4'h0);
    check("rst valid", evt_valid, 0);
    check("rst irq", irq, 0);
    check("rst ovf", overflow, 0);
    check("rst head", {evt_chan, evt_fall}, 3'b000);
    reset = 1'b1;

    // Single rising event on channel 1 with two-cycle latency
    raw_in = 4'b0010;
    exp_q.push_back({2'd1, 1'b0});
    wait_level(4'b0010, "s1 level");
    check("s1 lat0", evt_valid, 0);
    step(1);
    check("s1 lat1", evt_valid, 0);
    step(1);
    check("s1 lat2", evt_valid, 1);
    pop_check("s1 pop");
    check("s1 empty", evt_valid, 0);
    check("s1 irq low", irq, 0);

    // Return channel 1 low, then all four rise in one tick
    raw_in = 4'b0000;
    exp_q.push_back({2'd1, 1'b1});
    wait_level(4'b0000, "s2 level0");
    pop_check("s2 pop fall1");
    raw_in = 4'b1111;
    for (int c = 0; c < 4; c++) exp_q.push_back({2'(c), 1'b0});
    wait_level(4'b1111, "s2 levelF");
    step(6);
    check("s2 full valid", evt_valid, 1);
    check("s2 ovf", overflow, 0);
    head_exp = exp_q[0];
    check("s2 head", {evt_chan, evt_fall}, head_exp);
    for (int c = 0; c < 4; c++) pop_check("s2 drain");
    check("s2 drained", evt_valid, 0);

    // Fill with falls, then coalesce a second rise on channel 0
    raw_in = 4'b0000;
    for (int c = 0; c < 4; c++) exp_q.push_back({2'(c), 1'b1});
    wait_level(4'b0000, "s3 level0");
    step(6);
    raw_in = 4'b0001;
    exp_q.push_back({2'd0, 1'b0});
    wait_level(4'b0001, "s3 level1");
    step(2);
    check("s3 ovf before", overflow, 0);
    raw_in = 4'b0000;
    exp_q.push_back({2'd0, 1'b1});
    wait_level(4'b0000, "s3 level0b");
    step(2);
    check("s3 ovf new fall", overflow, 0);
    raw_in = 4'b0001;
    wait_level(4'b0001, "s3 level1b");
    step(2);
    check("s3 ovf set", overflow, 1);
    step(10);
    check("s3 ovf sticky", overflow, 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("s3 ovf clr", overflow, 0);
    for (int c = 0; c < 6; c++) pop_check("s3 drain");
    check("s3 drained", evt_valid, 0);

    // Only channel 2 falling enabled
    rise_en = 4'b0000;
    fall_en = 4'b0100;
    raw_in = 4'b0101;
    wait_level(4'b0101, "s4 level5");
    step(4);
    check("s4 no rise evt", evt_valid, 0);
    raw_in = 4'b0001;
    exp_q.push_back({2'd2, 1'b1});
    wait_level(4'b0001, "s4 level1");
    pop_check("s4 pop fall2");
    raw_in = 4'b0101;
    wait_level(4'b0101, "s4 level5b");
    step(4);
    check("s4 no rise evt2", evt_valid, 0);

    // Full FIFO plus one pending; single-cycle pop lets the pending one in
    rise_en = 4'hF;
    fall_en = 4'hF;
    raw_in = 4'b1010;
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd1, 1'b0});
    exp_q.push_back({2'd2, 1'b1});
    exp_q.push_back({2'd3, 1'b0});
    wait_level(4'b1010, "s5 levelA");
    step(6);
    raw_in = 4'b1011;
    exp_q.push_back({2'd0, 1'b0});
    wait_level(4'b1011, "s5 levelB");
    step(3);
    check("s5 ovf", overflow, 0);
    head_exp = exp_q.pop_front();
    check("s5 head before", {evt_chan, evt_fall}, head_exp);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    head_exp = exp_q[0];
    check("s5 head after", {evt_chan, evt_fall}, head_exp);
    check("s5 valid", evt_valid, 1);
    step(2);
    for (int c = 0; c < 4; c++) pop_check("s5 drain");
    check("s5 drained", evt_valid, 0);

    // Asynchronous reset with three entries queued
    raw_in = 4'b0000;
    wait_level(4'b0000, "s6 level0");
    step(5);
    check("s6 queued", evt_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("s6 rst valid", evt_valid, 0);
    check("s6 rst irq", irq, 0);
    check("s6 rst ovf", overflow, 0);
    check("s6 rst level", level_out, 4'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    step(30);
    check("s6 no stale", evt_valid, 0);
    check("s6 level", level_out, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Turns raw push-button/switch inputs into a queue of discrete edge events that the CPU consumes through a valid/ready pop port; also drives a level interrupt.
- Instantiates the team's existing debouncer (`debouncer`, shared timer) and registers the debounced levels.
- Per-channel pending flags feed a fixed-priority scheduler, which pushes at most one event per cycle into a small FIFO.
- Sits between the board I/O pins and the MMIO peripheral bus.

Parameters:
- WIDTH, 4: number of input channels (1..16).
- LGWAIT, 20: passed to `debouncer`; debounce sample period is 2^LGWAIT cycles.
- DEPTH_LG, 2: FIFO depth is 2^DEPTH_LG entries.
- CHW, 2: channel index width, must be at least clog2(WIDTH), minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- raw_in  in  WIDTH  undebounced pin levels.
- rise_en  in  WIDTH  per-channel enable for 0->1 events.
- fall_en  in  WIDTH  per-channel enable for 1->0 events.
- level_out  out  WIDTH  current debounced levels.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer pops the head when evt_valid & evt_ready.
- evt_chan  out  CHW  channel index of the head event.
- evt_fall  out  1  head event type: 1 = falling, 0 = rising.
- irq  out  1  equal to evt_valid.
- overflow  out  1  sticky flag: an event was coalesced/lost.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset: level_out=0, prev-level register=0, all pending flags=0, FIFO empty, evt_valid=0, irq=0, overflow=0. evt_chan/evt_fall=0 while empty.
- Edge detect: deb = debouncer output; prev <= deb every cycle. rise[i] = deb[i] & ~prev[i]; fall[i] = ~deb[i] & prev[i].
- Pending flags:
  - pend_r[i] is set on rise[i] & rise_en[i]; pend_f[i] is set on fall[i] & fall_en[i].
  - A flag clears only when its event is pushed.
  - Deasserting an enable does not clear an already-set flag.
- Scheduler:
  - Each cycle, select the lowest-index channel with any pending flag; on that channel, rise is served before fall.
  - Push iff the FIFO is not full at the start of the cycle.
  - Pushed entry = {chan, fall}; the pushed flag clears at the same edge.
- Latency: if the FIFO is empty and nothing else is pending, evt_valid rises 2 cycles after level_out changes (pend set at +1, push at +2).
- FIFO:
  - Registered full/empty; no combinational bypass.
  - Push and pop in the same cycle while non-empty and non-full: occupancy unchanged.
  - When full, push is blocked even if a pop occurs that cycle; the pending event waits one cycle.
  - Pop while empty is ignored.
  - Head outputs are stable while evt_valid & ~evt_ready.
- Overflow is set when a new enabled edge arrives on a flag that is already set and is not being pushed that cycle (the event is coalesced). It is also set if both rise and fall occur while a flag is held.
- ovf_clr clears overflow. If a set condition occurs in the same cycle, set wins.
- Debounced updates occur only on debouncer ticks, so all channel edges in a batch appear in one cycle. The scheduler drains them one per cycle in priority order.
- Reset asserted mid-operation flushes the FIFO and pending flags immediately (asynchronous).

Optional Feature:
- Macro: BUTTON_EVT_TIMESTAMP_EN.
- With the macro:
  - Adds output evt_time (16 bits) and a 16-bit free-running counter that increments on each debouncer tick (timer==0) and wraps from 0xFFFF to 0.
  - The counter value at push time is stored with the entry; FIFO width grows by 16.
  - The counter resets to 0.
- Without the macro: no counter and no evt_time port; FIFO entry is CHW+1 bits.

Decomposition:
- Shared package btn_evt_pkg:
  - event entry typedef {chan, fall[, time]};
  - TS_W=16 constant;
  - the channel-width helper function.
- One natural sub-module: btn_evt_fifo (parameterised-width synchronous FIFO with registered full/empty). The debouncer is instantiated as-is.

Test Plan (all scenarios use LGWAIT=3, WIDTH=4, DEPTH_LG=2):
- Reset with raw_in=4'b0000, rise_en=fall_en=4'hF, then raw_in=4'b0010 held -> after the next tick, level_out=0010; evt_valid 2 cycles later with chan=1, fall=0; irq=1; pop with ready -> evt_valid=0.
- raw_in 0000->1111 in one tick, ready=0 -> FIFO fills with chan 0,1,2,3 (all rise) in order; overflow=0; popping drains them in that order.
- Keep ready=0 with FIFO full and channel 0 pending rise, then toggle channel 0 high->low->high over two ticks -> overflow=1; ovf_clr pulse -> overflow=0.
- rise_en=0, fall_en=4'b0100: channel 2 goes 1->0 -> single event chan=2, fall=1; channel 2 rising produces no event.
- FIFO full with one pending event, pulse ready for 1 cycle -> head advances; pending event enters the next cycle; count returns to 4.
- Assert reset while 3 entries are queued -> evt_valid=0, irq=0, overflow=0 immediately; no stale events after release.
